// File: rtl/muldiv_ctrl.sv
// Execute-stage HI/LO sequencer: restoring 1-bit/cycle divider plus fixed-latency multiplier.
// Optional macro DIV_EARLY_OUT_EN: divides with |dividend| < |divisor| finish in one cycle.
module muldiv_ctrl #(
  parameter int unsigned MUL_LAT  = 2,
  parameter int unsigned DIV_BITS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_e,
  input  logic [7:0]  alucontrol_e,
  input  logic [31:0] srca_e,
  input  logic [31:0] srcb_e,
  input  logic        flush_e,
  output logic        stall_o,
  output logic        busy_o,
  output logic        hilo_we,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  // EXE_*_OP encodings from defines2.vh
  localparam logic [7:0] ExeMultOp  = 8'b0001_1000;
  localparam logic [7:0] ExeMultuOp = 8'b0001_1001;
  localparam logic [7:0] ExeDivOp   = 8'b0001_1010;
  localparam logic [7:0] ExeDivuOp  = 8'b0001_1011;

  localparam logic [7:0] LastDiv = 8'(DIV_BITS - 1);
  localparam logic [7:0] LastMul = 8'(MUL_LAT - 1);

  typedef enum logic [1:0] {StIdle, StDivRun, StMulRun, StDone} state_e;

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [31:0] rem_q, quo_q, dvs_q;
  logic        neg_quo_q, neg_rem_q;

  logic        is_mul, is_div, is_signed, start, running;
  logic [31:0] mag_a, mag_b;
  logic [63:0] ext_a, ext_b, prod;
  logic [32:0] rem_sh, rem_sub;
  logic [31:0] rem_nx, quo_nx, rem_fix, quo_fix;

  always_comb begin
    is_mul    = (alucontrol_e == ExeMultOp) || (alucontrol_e == ExeMultuOp);
    is_div    = (alucontrol_e == ExeDivOp)  || (alucontrol_e == ExeDivuOp);
    is_signed = (alucontrol_e == ExeMultOp) || (alucontrol_e == ExeDivOp);
    start     = valid_e && !flush_e && (state_q == StIdle) && (is_mul || is_div);
    running   = (state_q == StDivRun) || (state_q == StMulRun);

    mag_a = (is_signed && srca_e[31]) ? (~srca_e + 32'd1) : srca_e;
    mag_b = (is_signed && srcb_e[31]) ? (~srcb_e + 32'd1) : srcb_e;

    // Low 64 bits of the extended product equal the signed or unsigned 32x32 product.
    ext_a = {{32{is_signed & srca_e[31]}}, srca_e};
    ext_b = {{32{is_signed & srcb_e[31]}}, srcb_e};
    prod  = ext_a * ext_b;

    // rem_q < dvs_q always holds, so bit 32 of the difference is a clean borrow flag.
    rem_sh  = {rem_q, quo_q[31]};
    rem_sub = rem_sh - {1'b0, dvs_q};
    if (!rem_sub[32]) begin
      rem_nx = rem_sub[31:0];
      quo_nx = {quo_q[30:0], 1'b1};
    end else begin
      rem_nx = rem_sh[31:0];
      quo_nx = {quo_q[30:0], 1'b0};
    end
    quo_fix = neg_quo_q ? (~quo_nx + 32'd1) : quo_nx;
    rem_fix = neg_rem_q ? (~rem_nx + 32'd1) : rem_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_o      <= '0;
      lo_o      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cnt_q <= '0;
            if (is_mul) begin
              {rem_q, quo_q} <= prod;
              state_q        <= StMulRun;
            end else if (srcb_e == 32'd0) begin
              hi_o    <= srca_e;
              lo_o    <= '1;
              state_q <= StDone;
`ifdef DIV_EARLY_OUT_EN
            end else if (mag_a < mag_b) begin
              hi_o    <= srca_e;
              lo_o    <= '0;
              state_q <= StDone;
`endif
            end else begin
              rem_q     <= '0;
              quo_q     <= mag_a;
              dvs_q     <= mag_b;
              neg_quo_q <= is_signed & (srca_e[31] ^ srcb_e[31]);
              neg_rem_q <= is_signed & srca_e[31];
              state_q   <= StDivRun;
            end
          end
        end
        StDivRun: begin
          if (flush_e) begin
            state_q <= StIdle;
          end else begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt_q <= cnt_q + 8'd1;
            if (cnt_q == LastDiv) begin
              hi_o    <= rem_fix;
              lo_o    <= quo_fix;
              state_q <= StDone;
            end
          end
        end
        StMulRun: begin
          if (flush_e) begin
            state_q <= StIdle;
          end else if (cnt_q == LastMul) begin
            hi_o    <= rem_q;
            lo_o    <= quo_q;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign stall_o = !rst && !flush_e && (start || running);
  assign busy_o  = (state_q != StIdle);
  assign hilo_we = (state_q == StDone) && !flush_e;

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Execute-stage sequencer for the multi-cycle HI/LO unit. Handles MULT, MULTU, DIV and DIVU.
- Detects a mult/div operation from the 8-bit ALU control code, captures the operands, and runs a 1-bit-per-cycle restoring divider or a fixed-latency multiplier.
- Stalls the pipeline while busy and issues a single HI/LO write pulse with the 64-bit result.
- Sits beside the ALU in E; hi_o, lo_o and hilo_we feed the HI/LO register file.

Parameters:
- MUL_LAT, 2: multiply iteration cycles, legal range 1..8.
- DIV_BITS, 32: divider iterations, equal to the operand width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- valid_e  in  1  E-stage instruction valid.
- alucontrol_e  in  8  ALU control code of the E-stage instruction (`EXE_*_OP encodings from defines2.vh).
- srca_e  in  32  rs operand (dividend / multiplicand).
- srcb_e  in  32  rt operand (divisor / multiplier).
- flush_e  in  1  E-stage flush from exception or branch logic.
- stall_o  out  1  hold F/D/E stages.
- busy_o  out  1  FSM not IDLE.
- hilo_we  out  1  one-cycle HI/LO write strobe.
- hi_o  out  32  HI result (remainder or product[63:32]).
- lo_o  out  32  LO result (quotient or product[31:0]).

Behaviour:
- Definition: start = valid_e & ~flush_e & state==IDLE & alucontrol_e ∈ {`EXE_MULT_OP, `EXE_MULTU_OP, `EXE_DIV_OP, `EXE_DIVU_OP}.
- Reset (async): state IDLE, counter 0, hilo_we 0, hi_o/lo_o 0, busy_o 0. stall_o is forced 0 while rst is high.
- FSM states: IDLE, DIV_RUN, MUL_RUN, DONE.
- IDLE, start with DIV/DIVU, cycle T: latch |srca|, |srcb| (absolute values for DIV, raw for DIVU), quotient sign srca[31]^srcb[31], remainder sign srca[31]. Go to DIV_RUN with count=0.
- Divide by zero (srcb==0): go to DONE at T+1 instead of DIV_RUN. Result HI=srca_e, LO=32'hFFFFFFFF, for both DIV and DIVU.
- DIV_RUN: one restoring step per cycle. Shift {rem,quo} left by 1; if rem>=divisor, subtract and set the quotient LSB. After DIV_BITS steps, apply sign fix (two's-complement negate where the sign bit is set) and go to DONE. DONE occurs at T+DIV_BITS+1.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap, no special case required; this is the natural result.
- IDLE, start with MULT/MULTU: compute the 64-bit product (signed or unsigned) into the result register. Go to MUL_RUN; count MUL_LAT cycles, then DONE at T+MUL_LAT+1.
- DONE: hilo_we=1 for exactly this cycle with hi_o/lo_o valid. Then unconditionally IDLE; no restart even though the same instruction is still presented.
- hi_o/lo_o hold their last value until the next DONE.
- stall_o = start | state∈{DIV_RUN, MUL_RUN}. It is combinational and low in DONE, so E advances at the end of DONE.
- busy_o = state != IDLE.
- Operands are used only from the latched copies; srca_e/srcb_e changes after T are ignored.
- Flush: flush_e in DIV_RUN or MUL_RUN returns to IDLE next cycle with no hilo_we; stall_o drops the same cycle as the flush.
- Flush in DONE suppresses hilo_we.
- Flush concurrent with a would-be start: no start.
- Non-muldiv ops in IDLE: no effect, stall_o=0.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in the start cycle of DIV/DIVU, if |srca| < |srcb| (unsigned compare of latched magnitudes, divisor nonzero), skip DIV_RUN. Go to DONE at T+1 with LO=0, HI=srca_e (original signed value). stall_o is high only in cycle T.
- Undefined: all nonzero-divisor divides take the full DIV_BITS cycles.

Test Plan:
- DIVU srca=100, srcb=7, valid at T → stall_o high T..T+32; hilo_we only at T+33 with LO=14, HI=2.
- DIV srca=-7 (0xFFFFFFF9), srcb=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF at T+33. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- MULT srca=-3, srcb=5 with MUL_LAT=2 → hilo_we at T+3, HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULTU 0xFFFFFFFF*0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIVU srcb=0, srca=0x1234 → hilo_we at T+1, HI=0x1234, LO=0xFFFFFFFF. DIVU 3/10 → HI=3, LO=0; with DIV_EARLY_OUT_EN, hilo_we at T+1, otherwise at T+33.
- DIVU started at T, flush_e at T+10 → no hilo_we ever, stall_o=0 from T+10, busy_o=0 at T+11. A new DIVU 9/3 at T+12 gives LO=3, HI=0 at T+45.
- rst asserted at T+5 of a DIV → all outputs 0 immediately. After release, hi_o/lo_o stay 0 until the next op completes.
